// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter
// Small byte FIFO feeding a start/data/stop serializer; tx is registered one cycle behind the FSM state.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH   = (PW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          push, pop;

    // Gated by reset so the port reads not-ready while reset is held.
    assign in_ready = ~reset & (count_q < DEPTH);
    assign push     = in_valid & in_ready;
    assign tx       = tx_q;
    assign busy     = busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d = mem_q[head_q];
            head_d  = head_q + 1'b1;
        end
        if (push) tail_d = tail_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[bit_q];
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_q != IDLE) || (count_q != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= in_data;
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
// Scoreboard of accepted bytes checked by a 4-clock-per-bit receiver model on tx.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx;
    logic       busy;

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int frames_rx = 0;
    int acc_cyc;
    logic [7:0] exp_q[$];
    int frame_starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Receiver model: samples tx once per clock, 40 samples per frame.
    logic [39:0] s;
    int idx = 0;
    bit in_frame = 1'b0;

    task automatic score_frame();
        logic       shape_ok;
        logic [7:0] b;
        shape_ok = 1'b1;
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < 4; j++)
                if (s[4*k+j] !== s[4*k]) shape_ok = 1'b0;
        if (s[0] !== 1'b0 || s[36] !== 1'b1) shape_ok = 1'b0;
        for (int i = 0; i < 8; i++) b[i] = s[4*(i+1)];
        frames_rx++;
        check("bit_shape", int'(shape_ok), 1);
        check("frame_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("frame_byte", int'(b), int'(exp_q.pop_front()));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx == 1'b0) begin
                in_frame = 1'b1;
                s[0]     = 1'b0;
                idx      = 1;
                frame_starts.push_back(cyc);
            end
        end else begin
            s[idx] = tx;
            idx++;
            if (idx == 40) begin
                in_frame = 1'b0;
                score_frame();
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        repeat (2) @(negedge clk);
        for (int k = 0; k < budget; k++) begin
            if (!busy && !in_frame) break;
            @(negedge clk);
        end
        check("drain_idle", int'(busy), 0);
    endtask

    // Leaves in_valid high on return so consecutive calls stream back-to-back.
    task automatic send(input logic [7:0] b);
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 400 && !done; n++) begin
            if (in_ready) begin
                @(posedge clk);
                exp_q.push_back(b);
                done = 1'b1;
                #1;
                acc_cyc = cyc;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("send_accept", int'(done), 1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] pattern;
        int         busy_off;
    } vec_t;

    vec_t vecs[6];
    int   acc[6];
    logic [7:0] six[6];

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lows, snap, accepted;
        logic v;

        vecs[0] = '{8'hA5, 10'b1101001010, 42};
        vecs[1] = '{8'h00, 10'b1000000000, 42};
        vecs[2] = '{8'hFF, 10'b1111111110, 42};
        vecs[3] = '{8'h3C, 10'b1001111000, 42};
        vecs[4] = '{8'h01, 10'b1000000010, 42};
        vecs[5] = '{8'h80, 10'b1100000000, 42};

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", int'(tx), 1);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_tx", int'(tx), 1);
        check("post_rst_busy", int'(busy), 0);
        repeat (3) begin
            @(negedge clk);
            check("no_spurious_start", int'(tx), 1);
        end

        // Single frames: exact latency, bit levels and busy fall.
        for (int vi = 0; vi < 6; vi++) begin
            wait_idle(200);
            send(vecs[vi].data);
            in_valid = 1'b0;
            n = acc_cyc;
            wait_until(n + 1);
            check("pre_start_tx", int'(tx), 1);
            for (int i = 0; i < 10; i++) begin
                wait_until(n + 2 + 4*i);
                check("frame_bit", int'(tx), int'(vecs[vi].pattern[i]));
            end
            wait_until(n + vecs[vi].busy_off - 1);
            check("busy_before_end", int'(busy), 1);
            wait_until(n + vecs[vi].busy_off);
            check("busy_end", int'(busy), 0);
        end

        // Three back-to-back frames with no idle gap.
        wait_idle(200);
        frame_starts.delete();
        send(8'h00); send(8'hFF); send(8'h55);
        in_valid = 1'b0;
        wait_idle(400);
        check("b2b_frames", int'(frame_starts.size()), 3);
        if (frame_starts.size() == 3) begin
            check("b2b_gap1", frame_starts[1] - frame_starts[0], 40);
            check("b2b_gap2", frame_starts[2] - frame_starts[1], 40);
        end

        // Six bytes with in_valid held: buffer fills, ready returns after a pop.
        wait_idle(200);
        for (int i = 0; i < 6; i++) six[i] = 8'(8'h10 + 8'(i * 17));
        for (int i = 0; i < 6; i++) begin
            send(six[i]);
            acc[i] = acc_cyc;
            if (i == 4) check("full_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        check("fill_time", acc[4] - acc[0], 4);
        check("refill_time", acc[5] - acc[0], 42);
        wait_idle(600);

        // Reset mid-frame discards the frame and the buffered bytes.
        wait_idle(200);
        send(8'h3C);
        n = acc_cyc;
        send(8'h11); send(8'h22);
        in_valid = 1'b0;
        wait_until(n + 19);
        check("pre_abort_bit3", int'(tx), 1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_tx", int'(tx), 1);
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_busy", int'(busy), 0);
        exp_q.delete();
        snap = frames_rx;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_rel_in_ready", int'(in_ready), 1);
        check("abort_rel_busy", int'(busy), 0);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        check("abort_no_frame_tx", lows, 0);
        check("abort_no_frame_rx", frames_rx - snap, 0);
        check("abort_idle_busy", int'(busy), 0);

        // Random traffic: 500 accepted bytes checked by the receiver model.
        snap = frames_rx;
        accepted = 0;
        for (int it = 0; it < 60000 && accepted < 500; it++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            v = in_valid & in_ready;
            @(posedge clk);
            if (v) begin
                exp_q.push_back(in_data);
                accepted++;
            end
            #1;
        end
        in_valid = 1'b0;
        check("rand_accepted", accepted, 500);
        wait_idle(4000);
        check("rand_frames", frames_rx - snap, 500);
        check("rand_queue_empty", int'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, byte entries in the input buffer; power of two, legal range 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
REQ-005 in_valid  input  1  in_data holds a byte offered for transmission.
REQ-006 in_data  input  8  byte to transmit.
REQ-007 in_ready  output  1  block can accept a byte this cycle.
REQ-008 tx  output  1  serial line, idle high, registered output.
REQ-009 busy  output  1  frame in progress or buffer non-empty.

Function
REQ-010 Transfer occurs on a rising edge where in_valid and in_ready are both high; the byte is written to the FIFO tail.
REQ-011 in_ready = buffer count < FIFO_DEPTH, derived from registered count only; never depends on in_valid.
REQ-012 A pop and a push in the same cycle leave the count unchanged; both take effect.
REQ-013 A push into a full buffer cannot occur (in_ready low); a pop that frees space raises in_ready the following cycle, not the same cycle.
REQ-014 Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-015 Every bit, including the stop bit, is held on tx for exactly CLKS_PER_BIT cycles.
REQ-016 FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE: tx=1; if buffer non-empty, pop head into shift register, go START, tx=0 from the next edge.
REQ-018 START: after CLKS_PER_BIT cycles go DATA, bit index 0.
REQ-019 DATA: after each CLKS_PER_BIT cycles advance bit index; after index 7 completes go STOP.
REQ-020 STOP: tx=1; at end of CLKS_PER_BIT cycles, if buffer non-empty pop and go directly to START (no idle gap), else go IDLE.
REQ-021 Latency: byte accepted at edge N into empty buffer with FSM in IDLE -> tx low from edge N+2; frame ends (tx returns to idle level) at edge N+2+10*CLKS_PER_BIT.
REQ-022 Baud counter width = clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 then wraps; no cumulative drift across back-to-back frames.
REQ-023 Buffer pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-024 busy = (state != IDLE) or (count != 0); registered or combinational from registers only.
REQ-025 Bytes are transmitted in acceptance order; no byte dropped or duplicated.
REQ-026 in_data is not sampled outside a transfer cycle; changes while in_valid low have no effect.

Reset
REQ-027 While reset high: tx=1, in_ready=0, busy=0, state IDLE, counters and pointers zero.
REQ-028 Reset asserted mid-frame aborts immediately: tx goes 1 asynchronously, buffer contents discarded.
REQ-029 First cycle after reset deassertion: in_ready=1, tx=1, busy=0.
REQ-030 No spurious start bit (tx low) within 2 cycles after reset release when no byte is pushed.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Single byte 0xA5 pushed at edge N -> tx low at N+2; sampled bits 0,1,0,1,0,0,1,0,1,1 each 4 cycles; busy low at N+42.
REQ-032 Push 0x00, 0xFF, 0x55 back-to-back -> three contiguous 40-cycle frames, no idle cycle between stop and next start; payloads match.
REQ-033 Push 6 bytes with in_valid held high -> in_ready falls after 4th buffered byte, rises one cycle after each pop; all 6 bytes transmitted in order.
REQ-034 Assert reset during DATA bit 3 of 0x3C with 2 bytes buffered -> tx=1 immediately; after release no frame sent, busy=0, in_ready=1.
REQ-035 Random in_valid with random bytes for 500 frames, receiver model on tx -> output byte stream equals accepted stream; every bit width exactly 4 cycles.
